dtpm_cache_arbiter: RTL and testbench
=====================================

// Module: dtpm_cache_arbiter
// PURPOSE
//  Shares the single-port DTPM hash cache between two requesters:
//  - fetch lookup port (processor fetch addresses), high priority
//  - update port (loader writing {start,end,hash} entries), low priority
//  Sequences each access, returns registered lookup results to the TPM core, and bounds update starvation.
//  Sits between the fetch stage / hash loader and the cache storage.
// PARAMETERS
//  INST_ADDR_WIDTH  32  fetch/start/end address width
//  INDEX_WIDTH      7   cache index width (128 entries)
//  STARVE_LIMIT     4   consecutive fetch grants tolerated while an update is pending
// PORTS
//  clk              in   1    clock
//  reset            in   1    synchronous active-high reset
//  fetch_valid      in   1    lookup request
//  fetch_addr       in   IAW  address to look up
//  fetch_ready      out  1    lookup request accepted when valid&ready
//  lk_valid         out  1    1-cycle pulse: lookup result valid
//  lk_start_hit     out  1    fetch_addr matched a block start
//  lk_end_hit       out  1    fetch_addr matched a block end
//  lk_index         out  IW   index of matching end entry
//  lk_hash          out  128  stored hash of matching end entry
//  upd_valid        in   1    entry write request
//  upd_index        in   IW   entry to write
//  upd_start        in   IAW  block start address
//  upd_end          in   IAW  block end address
//  upd_hash         in   128  precomputed block hash
//  upd_ready        out  1    write accepted when valid&ready
//  cache_lkp_en     out  1    lookup strobe to cache
//  cache_lkp_addr   out  IAW  lookup address
//  cache_we         out  1    write strobe to cache
//  cache_widx       out  IW   write index
//  cache_wdata      out  2*IAW+128  {start,end,hash}
//  cache_hit_start  in   1    cache result, valid 1 cycle after cache_lkp_en
//  cache_hit_end    in   1    cache result
//  cache_rd_index   in   IW   cache result
//  cache_rd_hash    in   128  cache result
// BEHAVIOUR
//  - Reset: state=IDLE, starve_cnt=0; fetch_ready=upd_ready=1; lk_valid, lk_*, cache_lkp_en,
//    cache_we all 0; cache_lkp_addr, cache_widx, cache_wdata all 0.
//  - FSM: IDLE -> LKP_ISSUE -> LKP_WAIT -> IDLE (lookup); IDLE -> WRITE -> IDLE (update).
//  - Ready is high only in IDLE and only for the granted requester:
//    - fetch_ready=~(upd_valid & starve_cnt==STARVE_LIMIT)
//    - upd_ready=~fetch_valid | starve_cnt==STARVE_LIMIT
//  - Lookup (accept cycle T): T+1 cache_lkp_en=1, cache_lkp_addr=fetch_addr;
//    T+2 cache result sampled; T+3 lk_valid=1 with registered results; next accept at T+3.
//  - Miss: lk_valid still pulses, lk_start_hit=lk_end_hit=0, lk_index=0, lk_hash=0.
//    No tri-state values on any output.
//  - Start and end hit together: both flags set; lk_index/lk_hash come from the end entry.
//  - Write (accept cycle T): T+1 cache_we=1, cache_widx=upd_index, cache_wdata={start,end,hash};
//    back in IDLE at T+2. Writing start=end=0 invalidates the entry.
//  - Starvation: starve_cnt +1 (saturating at STARVE_LIMIT) on each fetch grant while upd_valid=1;
//    cleared on update grant or when upd_valid=0. At limit the next IDLE grant goes to update.
//  - Both valid in IDLE, starve_cnt<limit: fetch wins.
//  - Strobes cache_lkp_en/cache_we are 1-cycle pulses, never both high in the same cycle.
//  - One access outstanding at a time.
//  - Request inputs are sampled only at handshake; changes while not ready are ignored.
//  - Reset mid-operation: FSM to IDLE on that edge; aborted lookup produces no lk_valid;
//    aborted write is not issued if reset coincides with T+1.
// CONFIGURATION
//  DTPM_ARB_STATS_EN defined: adds outputs stat_lookups[31:0], stat_writes[31:0] and stat_forced[15:0]:
//    - lookups and writes counted at accept
//    - forced = update grants made because starve_cnt hit limit
//    - all wrap modulo width, cleared by reset
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Lookup hit: cache returns end hit idx 5, hash A5..A5 -> lk_valid at T+3, end_hit=1, idx=5, hash A5..A5.
//  2 Miss: fetch 0x1000, cache all-zero -> lk_valid pulse, flags 0, idx 0, hash 0.
//  3 Write: upd idx 3 {0x100,0x140,H} -> cache_we one cycle at T+1, widx=3, wdata={0x100,0x140,H}, upd_ready back at T+2.
//  4 Starvation: fetch_valid and upd_valid held high -> 4 lookups, then 1 write, then lookups resume; no overlapping strobes.
//  5 Reset asserted in LKP_WAIT -> no lk_valid, fetch_ready=1 the cycle after reset release.
//  6 STATS_EN: 10 lookups, 3 writes, 1 forced -> stat_lookups=10, stat_writes=3, stat_forced=1.

Source files
------------

// File: rtl/dtpm_cache_arbiter.sv
//------------------------------------------------------------------------------
// Module      : dtpm_cache_arbiter
// Description : Shares the single-port DTPM hash cache between a high-priority
//               fetch lookup port and a low-priority entry update port.
//               Each lookup is issued, its cache result sampled and returned
//               as a registered one-cycle pulse. Each update becomes a single
//               write strobe. A saturating counter makes sure the update port
//               cannot be starved by a steady fetch stream.
//               Optional statistics counters are built when the macro
//               DTPM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dtpm_cache_arbiter #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int INDEX_WIDTH     = 7,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               fetch_valid,
  input  logic [INST_ADDR_WIDTH-1:0]         fetch_addr,
  output logic                               fetch_ready,
  output logic                               lk_valid,
  output logic                               lk_start_hit,
  output logic                               lk_end_hit,
  output logic [INDEX_WIDTH-1:0]             lk_index,
  output logic [127:0]                       lk_hash,
  input  logic                               upd_valid,
  input  logic [INDEX_WIDTH-1:0]             upd_index,
  input  logic [INST_ADDR_WIDTH-1:0]         upd_start,
  input  logic [INST_ADDR_WIDTH-1:0]         upd_end,
  input  logic [127:0]                       upd_hash,
  output logic                               upd_ready,
  output logic                               cache_lkp_en,
  output logic [INST_ADDR_WIDTH-1:0]         cache_lkp_addr,
  output logic                               cache_we,
  output logic [INDEX_WIDTH-1:0]             cache_widx,
  output logic [2*INST_ADDR_WIDTH+127:0]     cache_wdata,
  input  logic                               cache_hit_start,
  input  logic                               cache_hit_end,
  input  logic [INDEX_WIDTH-1:0]             cache_rd_index,
  input  logic [127:0]                       cache_rd_hash
`ifdef DTPM_ARB_STATS_EN
  ,
  output logic [31:0]                        stat_lookups,
  output logic [31:0]                        stat_writes,
  output logic [15:0]                        stat_forced
`endif
);

  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_starve_w-1:0] c_starve_limit = c_starve_w'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LKP_ISSUE = 2'd1,
    ST_LKP_WAIT  = 2'd2,
    ST_WRITE     = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_starve_w-1:0]   r_starve_cnt;
  logic                    w_at_limit;
  logic                    w_fetch_grant;
  logic                    w_upd_grant;

  assign w_at_limit = (r_starve_cnt == c_starve_limit);

  // State register; reset drops any in-flight access back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshakes; only IDLE offers ready, and only to the winner.
  always_comb begin
    w_state_next  = r_state;
    fetch_ready   = 1'b0;
    upd_ready     = 1'b0;
    w_fetch_grant = 1'b0;
    w_upd_grant   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        fetch_ready   = ~(upd_valid & w_at_limit);
        upd_ready     = ~fetch_valid | w_at_limit;
        w_fetch_grant = fetch_valid & ~(upd_valid & w_at_limit);
        w_upd_grant   = upd_valid & (~fetch_valid | w_at_limit);
        if (w_fetch_grant) begin
          w_state_next = ST_LKP_ISSUE;
        end else if (w_upd_grant) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_LKP_ISSUE: w_state_next = ST_LKP_WAIT;
      ST_LKP_WAIT:  w_state_next = ST_IDLE;
      ST_WRITE:     w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Starvation counter: counts fetch wins while an update waits, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!upd_valid || w_upd_grant) begin
      r_starve_cnt <= '0;
    end else if (w_fetch_grant && !w_at_limit) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Cache-side strobes; request fields are captured only on the grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_lkp_en   <= 1'b0;
      cache_lkp_addr <= '0;
      cache_we       <= 1'b0;
      cache_widx     <= '0;
      cache_wdata    <= '0;
    end else begin
      cache_lkp_en <= w_fetch_grant;
      cache_we     <= w_upd_grant;
      if (w_fetch_grant) begin
        cache_lkp_addr <= fetch_addr;
      end
      if (w_upd_grant) begin
        cache_widx  <= upd_index;
        cache_wdata <= {upd_start, upd_end, upd_hash};
      end
    end
  end

  // Lookup result capture; index/hash describe the end entry and read 0 without an end hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk_valid     <= 1'b0;
      lk_start_hit <= 1'b0;
      lk_end_hit   <= 1'b0;
      lk_index     <= '0;
      lk_hash      <= '0;
    end else begin
      lk_valid <= (r_state == ST_LKP_WAIT);
      if (r_state == ST_LKP_WAIT) begin
        lk_start_hit <= cache_hit_start;
        lk_end_hit   <= cache_hit_end;
        lk_index     <= cache_hit_end ? cache_rd_index : '0;
        lk_hash      <= cache_hit_end ? cache_rd_hash  : '0;
      end
    end
  end

`ifdef DTPM_ARB_STATS_EN
  // Access statistics, counted at accept and wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_writes  <= '0;
      stat_forced  <= '0;
    end else begin
      if (w_fetch_grant) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (w_upd_grant) begin
        stat_writes <= stat_writes + 32'd1;
      end
      if (w_upd_grant && w_at_limit && fetch_valid) begin
        stat_forced <= stat_forced + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dtpm_cache_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_dtpm_cache_arbiter
// Description : Directed self-checking bench for dtpm_cache_arbiter with a
//               small registered cache responder. Statistics checks are built
//               when DTPM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dtpm_cache_arbiter;

  localparam int IAW = 32;
  localparam int IW  = 7;

  localparam logic [127:0] c_hash_a5  = {16{8'hA5}};
  localparam logic [127:0] c_hash_b   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] c_hash_upd = 128'hDEADBEEF_CAFEBABE_00112233_44556677;

  logic               clk;
  logic               reset;
  logic               fetch_valid;
  logic [IAW-1:0]     fetch_addr;
  logic               fetch_ready;
  logic               lk_valid;
  logic               lk_start_hit;
  logic               lk_end_hit;
  logic [IW-1:0]      lk_index;
  logic [127:0]       lk_hash;
  logic               upd_valid;
  logic [IW-1:0]      upd_index;
  logic [IAW-1:0]     upd_start;
  logic [IAW-1:0]     upd_end;
  logic [127:0]       upd_hash;
  logic               upd_ready;
  logic               cache_lkp_en;
  logic [IAW-1:0]     cache_lkp_addr;
  logic               cache_we;
  logic [IW-1:0]      cache_widx;
  logic [2*IAW+127:0] cache_wdata;
  logic               cache_hit_start;
  logic               cache_hit_end;
  logic [IW-1:0]      cache_rd_index;
  logic [127:0]       cache_rd_hash;
`ifdef DTPM_ARB_STATS_EN
  logic [31:0]        stat_lookups;
  logic [31:0]        stat_writes;
  logic [15:0]        stat_forced;
`endif

  int total = 0;
  int bad   = 0;

  dtpm_cache_arbiter #(
    .INST_ADDR_WIDTH (IAW),
    .INDEX_WIDTH     (IW),
    .STARVE_LIMIT    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .fetch_addr      (fetch_addr),
    .fetch_ready     (fetch_ready),
    .lk_valid        (lk_valid),
    .lk_start_hit    (lk_start_hit),
    .lk_end_hit      (lk_end_hit),
    .lk_index        (lk_index),
    .lk_hash         (lk_hash),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_start       (upd_start),
    .upd_end         (upd_end),
    .upd_hash        (upd_hash),
    .upd_ready       (upd_ready),
    .cache_lkp_en    (cache_lkp_en),
    .cache_lkp_addr  (cache_lkp_addr),
    .cache_we        (cache_we),
    .cache_widx      (cache_widx),
    .cache_wdata     (cache_wdata),
    .cache_hit_start (cache_hit_start),
    .cache_hit_end   (cache_hit_end),
    .cache_rd_index  (cache_rd_index),
    .cache_rd_hash   (cache_rd_hash)
`ifdef DTPM_ARB_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_writes     (stat_writes),
    .stat_forced     (stat_forced)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache responder: result appears the cycle after the lookup strobe, zero otherwise.
  always @(posedge clk) begin
    cache_hit_start <= 1'b0;
    cache_hit_end   <= 1'b0;
    cache_rd_index  <= '0;
    cache_rd_hash   <= '0;
    if (cache_lkp_en) begin
      case (cache_lkp_addr)
        32'h0000_2000: begin
          cache_hit_end  <= 1'b1;
          cache_rd_index <= 7'd5;
          cache_rd_hash  <= c_hash_a5;
        end
        32'h0000_3000: begin
          cache_hit_start <= 1'b1;
        end
        32'h0000_4000: begin
          cache_hit_start <= 1'b1;
          cache_hit_end   <= 1'b1;
          cache_rd_index  <= 7'd9;
          cache_rd_hash   <= c_hash_b;
        end
        default: ;
      endcase
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_lookup(input logic [IAW-1:0] addr, input logic exp_s, input logic exp_e,
                           input logic [IW-1:0] exp_idx, input logic [127:0] exp_hash);
    fetch_valid = 1'b1;
    fetch_addr  = addr;
    #1;
    check("lkp_accept_ready", fetch_ready, 1'b1);
    tick();
    fetch_valid = 1'b0;
    fetch_addr  = 32'hDEAD_0000;
    #1;
    check("lkp_t1_en", cache_lkp_en, 1'b1);
    check("lkp_t1_addr", cache_lkp_addr, addr);
    check("lkp_t1_busy", fetch_ready, 1'b0);
    tick();
    check("lkp_t2_en", cache_lkp_en, 1'b0);
    check("lkp_t2_addr_hold", cache_lkp_addr, addr);
    check("lkp_t2_no_valid", lk_valid, 1'b0);
    tick();
    check("lkp_t3_valid", lk_valid, 1'b1);
    check("lkp_t3_start", lk_start_hit, exp_s);
    check("lkp_t3_end", lk_end_hit, exp_e);
    check("lkp_t3_index", lk_index, exp_idx);
    check("lkp_t3_hash", lk_hash, exp_hash);
    check("lkp_t3_ready", fetch_ready, 1'b1);
    tick();
    check("lkp_t4_pulse", lk_valid, 1'b0);
  endtask

  task automatic do_write(input logic [IW-1:0] idx, input logic [IAW-1:0] s,
                          input logic [IAW-1:0] e, input logic [127:0] h);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_start = s;
    upd_end   = e;
    upd_hash  = h;
    #1;
    check("wr_accept_ready", upd_ready, 1'b1);
    tick();
    upd_valid = 1'b0;
    upd_index = 7'd127;
    upd_start = 32'hFFFF_FFFF;
    #1;
    check("wr_t1_we", cache_we, 1'b1);
    check("wr_t1_widx", cache_widx, idx);
    check("wr_t1_wdata", cache_wdata, {s, e, h});
    check("wr_t1_no_lkp", cache_lkp_en, 1'b0);
    check("wr_t1_busy", upd_ready, 1'b0);
    tick();
    check("wr_t2_we", cache_we, 1'b0);
    check("wr_t2_ready", upd_ready, 1'b1);
  endtask

  initial begin
    logic [11:0] seq;
    int          nev;
    int          overlap;
    int          wcyc;
    logic [IW-1:0] widx_seen;

    reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_addr  = '0;
    upd_valid   = 1'b0;
    upd_index   = '0;
    upd_start   = '0;
    upd_end     = '0;
    upd_hash    = '0;

    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_fetch_ready", fetch_ready, 1'b1);
    check("rst_upd_ready", upd_ready, 1'b1);
    check("rst_lk_valid", lk_valid, 1'b0);
    check("rst_lk_flags", {lk_start_hit, lk_end_hit}, 2'b00);
    check("rst_lk_index", lk_index, 7'd0);
    check("rst_lk_hash", lk_hash, 128'd0);
    check("rst_strobes", {cache_lkp_en, cache_we}, 2'b00);
    check("rst_lkp_addr", cache_lkp_addr, 32'd0);
    check("rst_widx", cache_widx, 7'd0);
    check("rst_wdata", cache_wdata, 192'd0);

    // Lookup variants: end hit, miss, start-only, start and end together.
    tick();
    do_lookup(32'h0000_2000, 1'b1 ^ 1'b1, 1'b1, 7'd5, c_hash_a5);
    do_lookup(32'h0000_1000, 1'b0, 1'b0, 7'd0, 128'd0);
    do_lookup(32'h0000_3000, 1'b1, 1'b0, 7'd0, 128'd0);
    do_lookup(32'h0000_4000, 1'b1, 1'b1, 7'd9, c_hash_b);

    // Writes: a normal entry then an invalidation.
    do_write(7'd3, 32'h0000_0100, 32'h0000_0140, c_hash_upd);
    do_write(7'd3, 32'h0, 32'h0, 128'd0);

    // Starvation: both ports held busy.
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0000_2000;
    upd_valid   = 1'b1;
    upd_index   = 7'd12;
    upd_start   = 32'h0000_0500;
    upd_end     = 32'h0000_0540;
    upd_hash    = c_hash_upd;
    seq       = '0;
    nev       = 0;
    overlap   = 0;
    wcyc      = -1;
    widx_seen = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (cache_lkp_en && cache_we) overlap++;
      if (cache_lkp_en) begin
        if (nev < 6) seq = {seq[9:0], 2'b01};
        nev++;
      end
      if (cache_we) begin
        if (nev < 6) seq = {seq[9:0], 2'b10};
        nev++;
        wcyc      = c;
        widx_seen = cache_widx;
      end
    end
    fetch_valid = 1'b0;
    upd_valid   = 1'b0;
    check("starve_sequence", seq, 12'b01_01_01_01_10_01);
    check("starve_event_count", nev, 7);
    check("starve_write_cycle", wcyc, 13);
    check("starve_write_index", widx_seen, 7'd12);
    check("starve_no_overlap", overlap, 0);
    tick();
    tick();

`ifdef DTPM_ARB_STATS_EN
    check("stat_lookups", stat_lookups, 32'd10);
    check("stat_writes", stat_writes, 32'd3);
    check("stat_forced", stat_forced, 16'd1);
`endif

    // Reset while the lookup waits on the cache.
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0000_2000;
    tick();
    fetch_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rstmid_no_valid", lk_valid, 1'b0);
    check("rstmid_no_lkp", cache_lkp_en, 1'b0);
    reset = 1'b0;
    tick();
    check("rstmid_after_valid", lk_valid, 1'b0);
    check("rstmid_after_ready", fetch_ready, 1'b1);

    // Reset on the edge that would issue a write.
    upd_valid = 1'b1;
    upd_index = 7'd4;
    #1;
    check("rstwr_ready", upd_ready, 1'b1);
    reset = 1'b1;
    tick();
    check("rstwr_no_we", cache_we, 1'b0);
    upd_valid = 1'b0;
    reset     = 1'b0;
    tick();
    check("rstwr_after_we", cache_we, 1'b0);
    check("rstwr_after_ready", upd_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
